dmem_wait_stage: RTL and testbench

Parametrised data-memory stage for the ARM pipeline MEM slot. It decodes the ALU-computed byte address against a configurable base, bounds-checks it and performs word reads/writes on an internal array. It models a memory with a configurable wait-state count, and it holds the pipeline through a ready/freeze handshake until each access completes. It replaces the fixed single-cycle 64-word memory and adds range/alignment error detection.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_wait_stage.sv | 93 +++++++++
 tb/tb_dmem_wait_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and address decode for the wait-state data-memory stage.
package dmem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] index;
  } dmem_decode_t;

  function automatic int unsigned word_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Borrow, range and alignment checks on the byte offset from the array base.
  function automatic dmem_decode_t decode_addr(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input int unsigned depth,
                                               input int unsigned wbytes);
    logic [32:0]  off;
    dmem_decode_t dec;
    off       = {1'b0, addr} - {1'b0, base};
    dec.valid = ~off[32]
                && (off[31:0] < 32'(depth * wbytes))
                && ((off[31:0] % 32'(wbytes)) == 32'd0);
    dec.index = off[31:0] / 32'(wbytes);
    return dec;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, no reset.
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_wait_stage.sv
// MEM-slot data memory with configurable wait states and a ready/freeze
// handshake; flags out-of-range and misaligned accesses on completion.
module dmem_wait_stage
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [DATA_W-1:0] Val_Rm,
  output logic [DATA_W-1:0] MEM_result,
  output logic              ready,
  output logic              addr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WB = word_bytes(DATA_W);
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_t            r_state;
  logic [CW-1:0]     r_wait_cnt;
  dmem_decode_t      w_dec;
  logic              w_valid;
  logic              w_req;
  logic              w_last;
  logic              w_done;
  logic              w_we;
  logic [AW-1:0]     w_index;
  logic [DATA_W-1:0] w_rdata;

  // Upper index bits are zero whenever the range check passes; kept as a guard.
  assign w_dec   = decode_addr(ALU_Res, 32'(BASE_ADDR), DEPTH, WB);
  assign w_valid = w_dec.valid && ((w_dec.index >> AW) == 32'd0);
  assign w_index = w_dec.index[AW-1:0];

  assign w_req  = MEM_R_EN | MEM_W_EN;
  assign w_last = (WAIT_CYCLES == 0)
                  || ((r_state == ST_WAIT) && (r_wait_cnt == CW'(WAIT_CYCLES)));
  // A reset in the would-be completion cycle aborts the access outright.
  assign w_done = w_req && w_last && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && (WAIT_CYCLES > 0)) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= CW'(1);
          end
        end
        ST_WAIT: begin
          if (!w_req || w_done) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign w_we = w_done && MEM_W_EN && w_valid;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_index),
    .i_wdata (Val_Rm),
    .o_rdata (w_rdata)
  );

  assign MEM_result = (w_done && MEM_R_EN && !MEM_W_EN && w_valid) ? w_rdata : '0;
  assign ready      = !w_req || w_done;
  assign addr_err   = w_done && !w_valid;

endmodule

// File: tb/tb_dmem_wait_stage.sv
// Bench for dmem_wait_stage: four instances with 0..3 wait states, directed
// vector table, hand-written corner sequences and a random model-checked phase.
module tb_dmem_wait_stage;

  logic        clk;
  logic        rst   [4];
  logic        r_en  [4];
  logic        w_en  [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  wire  [31:0] result[4];
  wire         rdy   [4];
  wire         err   [4];

  int n_chk;
  int n_fail;

  logic [31:0] mem_m   [4][64];
  bit          known_m [4][64];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_wait_stage #(
      .DATA_W      (32),
      .DEPTH       (64),
      .BASE_ADDR   (1024),
      .WAIT_CYCLES (g)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .MEM_R_EN   (r_en[g]),
      .MEM_W_EN   (w_en[g]),
      .ALU_Res    (addr[g]),
      .Val_Rm     (wdata[g]),
      .MEM_result (result[g]),
      .ready      (rdy[g]),
      .addr_err   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_res;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[12];

  function automatic bit m_valid(input logic [31:0] a);
    return (a >= 32'd1024) && (a < 32'd1280) && ((a % 32'd4) == 32'd0);
  endfunction

  function automatic int m_index(input logic [31:0] a);
    return int'((a - 32'd1024) / 32'd4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One access on instance k, entered just after a rising edge; returns just
  // after the edge that ends the completion cycle, inputs still driven.
  task automatic access(input int k, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_res, input logic exp_err,
                        input bit data_known, input string nm);
    w_en[k] = we; r_en[k] = re; addr[k] = a; wdata[k] = d;
    for (int c = 0; c <= k; c++) begin
      @(negedge clk);
      chk({nm, "/ready"}, {31'b0, rdy[k]}, {31'b0, (c == k)});
      chk({nm, "/err"}, {31'b0, err[k]}, (c == k) ? {31'b0, exp_err} : 32'd0);
      if (c != k || data_known) chk({nm, "/data"}, result[k], (c == k) ? exp_res : 32'd0);
      @(posedge clk); #1;
    end
    if (we && m_valid(a)) begin
      mem_m[k][m_index(a)]   = d;
      known_m[k][m_index(a)] = 1'b1;
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      r_en[k] = 1'b0; w_en[k] = 1'b0;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; r_en[k] = 1'b0; w_en[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
      for (int i = 0; i < 64; i++) known_m[k][i] = 1'b0;
    end

    vecs[0]  = '{2, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0,        1'b0, "n2_wr_1024"};
    vecs[1]  = '{2, 1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0, "n2_rd_1024"};
    vecs[2]  = '{2, 1'b0, 1'b1, 32'd1020, 32'h0,        32'h0,        1'b1, "n2_rd_below"};
    vecs[3]  = '{2, 1'b1, 1'b0, 32'd1280, 32'h0000BAD1, 32'h0,        1'b1, "n2_wr_above"};
    vecs[4]  = '{2, 1'b1, 1'b0, 32'd1026, 32'h0000BAD2, 32'h0,        1'b1, "n2_wr_misal"};
    vecs[5]  = '{2, 1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF, 1'b0, "n2_rd_untouched"};
    vecs[6]  = '{2, 1'b1, 1'b0, 32'd1276, 32'hCAFE0001, 32'h0,        1'b0, "n2_wr_last"};
    vecs[7]  = '{2, 1'b0, 1'b1, 32'd1276, 32'h0,        32'hCAFE0001, 1'b0, "n2_rd_last"};
    vecs[8]  = '{2, 1'b1, 1'b1, 32'd1036, 32'h00000055, 32'h0,        1'b0, "n2_both"};
    vecs[9]  = '{2, 1'b0, 1'b1, 32'd1036, 32'h0,        32'h00000055, 1'b0, "n2_rd_both"};
    vecs[10] = '{0, 1'b1, 1'b0, 32'd1028, 32'h00000011, 32'h0,        1'b0, "n0_wr_1028"};
    vecs[11] = '{0, 1'b0, 1'b1, 32'd1028, 32'h0,        32'h00000011, 1'b0, "n0_rd_1028"};

    // Reset with no request pending
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst%0d/ready", k), {31'b0, rdy[k]}, 32'd1);
      chk($sformatf("rst%0d/data", k), result[k], 32'd0);
      chk($sformatf("rst%0d/err", k), {31'b0, err[k]}, 32'd0);
    end
    @(posedge clk); #1;

    // Directed vectors, back-to-back per instance
    for (int v = 0; v < 12; v++)
      access(vecs[v].k, vecs[v].we, vecs[v].re, vecs[v].a, vecs[v].d,
             vecs[v].exp_res, vecs[v].exp_err, 1'b1, vecs[v].name);
    idle_all();
    @(negedge clk);
    chk("n2_idle/ready", {31'b0, rdy[2]}, 32'd1);
    @(posedge clk); #1;

    // Reset in cycle 1 of a write (N=3) aborts it; FSM restarts from IDLE
    access(3, 1'b1, 1'b0, 32'd1032, 32'hAAAA0001, 32'h0, 1'b0, 1'b1, "n3_pre_wr");
    w_en[3] = 1'b1; r_en[3] = 1'b0; addr[3] = 32'd1032; wdata[3] = 32'hBBBB0002;
    @(negedge clk);
    chk("n3_abort_c0/ready", {31'b0, rdy[3]}, 32'd0);
    @(posedge clk); #1;
    rst[3] = 1'b1;
    @(negedge clk);
    chk("n3_abort_c1/ready", {31'b0, rdy[3]}, 32'd0);
    chk("n3_abort_c1/err", {31'b0, err[3]}, 32'd0);
    @(posedge clk); #1;
    rst[3] = 1'b0;
    access(3, 1'b0, 1'b1, 32'd1032, 32'h0, 32'hAAAA0001, 1'b0, 1'b1, "n3_rd_after_rst");
    idle_all();

    // Request held across completion (N=1): two distinct reads
    access(1, 1'b1, 1'b0, 32'd1040, 32'h12345678, 32'h0, 1'b0, 1'b1, "n1_wr");
    w_en[1] = 1'b0; r_en[1] = 1'b1; addr[1] = 32'd1040;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("n1_b2b_c%0d/ready", c), {31'b0, rdy[1]}, {31'b0, (c % 2 == 1)});
      chk($sformatf("n1_b2b_c%0d/data", c), result[1], (c % 2 == 1) ? 32'h12345678 : 32'h0);
      @(posedge clk); #1;
    end
    idle_all();
    @(posedge clk); #1;

    // Random accesses against the word-array model
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 40; i++) begin
        int unsigned op;
        logic        we, re, ok, kn;
        logic [31:0] a, d, er;
        op = $urandom_range(0, 9);
        if (op == 0) begin
          r_en[k] = 1'b0; w_en[k] = 1'b0;
          @(negedge clk);
          chk($sformatf("rnd%0d_%0d_idle/ready", k, i), {31'b0, rdy[k]}, 32'd1);
          chk($sformatf("rnd%0d_%0d_idle/data", k, i), result[k], 32'd0);
          @(posedge clk); #1;
        end else begin
          we = (op < 5);
          re = (op >= 4);
          a  = 32'd1016 + 32'($urandom_range(0, 68)) * 32'd4;
          if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
          d  = $urandom;
          ok = m_valid(a);
          kn = 1'b1;
          er = 32'h0;
          if (re && !we && ok) begin
            kn = known_m[k][m_index(a)];
            er = mem_m[k][m_index(a)];
          end
          access(k, we, re, a, d, er, !ok, kn, $sformatf("rnd%0d_%0d", k, i));
        end
      end
      r_en[k] = 1'b0; w_en[k] = 1'b0;
    end

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
